mul_rep_add: RTL and testbench



---
 rtl/mul_rep_add_pkg.sv | 15 +
 rtl/eqz_n.sv | 14 +
 rtl/mul_rep_add.sv | 99 +++++++++
 tb/tb_mul_rep_add.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rep_add_pkg.sv
// rtl/mul_rep_add_pkg.sv - shared types and defaults for the repeated-addition multiplier
// Contents:
//   WIDTH_DEF : default operand width
//   state_t   : controller states (IDLE, ADD, DONE), 2-bit encoding
package mul_rep_add_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/eqz_n.sv
// rtl/eqz_n.sv - parametrised combinational equal-to-zero detector
// Ports:
//   data : input  [WIDTH-1:0] value under test
//   eqz  : output             1 when data is all zeros
module eqz_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             eqz
);

  assign eqz = (data == '0);

endmodule

// File: rtl/mul_rep_add.sv
// rtl/mul_rep_add.sv - unsigned sequential multiplier using repeated addition
// Ports:
//   clk     : input               rising-edge clock
//   rst     : input               synchronous active-high reset
//   start   : input               request, sampled only in IDLE
//   data_a  : input  [WIDTH-1:0]  multiplicand, sampled with start
//   data_b  : input  [WIDTH-1:0]  multiplier, sampled with start
//   busy    : output              high while in ADD
//   done    : output              one-cycle pulse, product valid
//   product : output [2*WIDTH-1:0] accumulator; holds until the next accepted start
//   eqz     : output              count register is zero
module mul_rep_add
  import mul_rep_add_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MIN_COUNT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 eqz
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   areg;
  logic [WIDTH-1:0]   cnt;
  logic [2*WIDTH-1:0] preg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   count;
  logic               swap;

  eqz_n #(.WIDTH(WIDTH)) u_eqz (
    .data (cnt),
    .eqz  (eqz)
  );

  // In MIN_COUNT mode the smaller operand becomes the loop count so the
  // latency is bounded by min(A,B)+1; ties keep the original order.
  assign swap   = MIN_COUNT && (data_a < data_b);
  assign addend = swap ? data_b : data_a;
  assign count  = swap ? data_a : data_b;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (eqz) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      areg  <= '0;
      cnt   <= '0;
      preg  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            preg <= '0;
            areg <= addend;
            cnt  <= count;
          end
        end
        ADD: begin
          // Zero test comes before the decrement, so cnt never wraps.
          if (!eqz) begin
            preg <= preg + {{WIDTH{1'b0}}, areg};
            cnt  <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = preg;

endmodule

// File: tb/tb_mul_rep_add.sv
// tb/tb_mul_rep_add.sv - self-checking bench for mul_rep_add
module tb_mul_rep_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // inst 0: WIDTH=16 MIN_COUNT=0, inst 1: WIDTH=4 MIN_COUNT=0, inst 2: WIDTH=16 MIN_COUNT=1
  logic        start0 = 0, start1 = 0, start2 = 0;
  logic [15:0] a0 = 0, b0 = 0, a2 = 0, b2 = 0;
  logic [3:0]  a1 = 0, b1 = 0;
  logic        busy0, busy1, busy2, done0, done1, done2, eqz0, eqz1, eqz2;
  logic [31:0] p0, p2;
  logic [7:0]  p1;

  mul_rep_add #(.WIDTH(16), .MIN_COUNT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_a(a0), .data_b(b0),
    .busy(busy0), .done(done0), .product(p0), .eqz(eqz0));

  mul_rep_add #(.WIDTH(4), .MIN_COUNT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_a(a1), .data_b(b1),
    .busy(busy1), .done(done1), .product(p1), .eqz(eqz1));

  mul_rep_add #(.WIDTH(16), .MIN_COUNT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_a(a2), .data_b(b2),
    .busy(busy2), .done(done2), .product(p2), .eqz(eqz2));

  typedef struct {
    int          inst;
    logic [31:0] prod;
    int          lat;
  } sb_t;
  sb_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic set_in(input int inst, input logic s, input logic [15:0] a, input logic [15:0] b);
    case (inst)
      0: begin start0 = s; a0 = a; b0 = b; end
      1: begin start1 = s; a1 = a[3:0]; b1 = b[3:0]; end
      default: begin start2 = s; a2 = a; b2 = b; end
    endcase
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy2;
  endfunction

  function automatic logic get_eqz(input int inst);
    return (inst == 0) ? eqz0 : (inst == 1) ? eqz1 : eqz2;
  endfunction

  function automatic logic [31:0] get_prod(input int inst);
    return (inst == 0) ? p0 : (inst == 1) ? {24'd0, p1} : p2;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (get_prod(i) !== 32'd0 || get_done(i) !== 1'b0 || get_busy(i) !== 1'b0 || get_eqz(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: prod=%0d done=%b busy=%b eqz=%b, want 0/0/0/1",
                 i, get_prod(i), get_done(i), get_busy(i), get_eqz(i));
      end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (get_prod(i) !== 32'd0 || get_done(i) !== 1'b0 || get_busy(i) !== 1'b0 || get_eqz(i) !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_quiet inst%0d: prod=%0d done=%b busy=%b eqz=%b, want 0/0/0/1",
                 i, get_prod(i), get_done(i), get_busy(i), get_eqz(i));
      end
    end
  endtask

  // One multiply: expected result and latency go on the scoreboard when the
  // operands are driven, and are popped when done is observed.
  task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input bit poke_busy, input bit poke_done);
    sb_t         it;
    int          lat, busyc;
    logic [15:0] cnt_e;
    cnt_e   = (inst == 2 && a < b) ? a : b;
    it.inst = inst;
    it.prod = 32'(a) * 32'(b);
    it.lat  = int'(cnt_e) + 1;
    sb.push_back(it);

    @(negedge clk);
    set_in(inst, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(inst, 1'b0, a, b);
    lat   = 0;
    busyc = 0;
    while (!get_done(inst) && lat < int'(cnt_e) + 20) begin
      if (get_busy(inst)) busyc++;
      if (poke_busy) set_in(inst, 1'b1, ~a, ~b);
      @(posedge clk);
      @(negedge clk);
      lat++;
      set_in(inst, 1'b0, a, b);
    end

    it = sb.pop_front();
    n_vec++;
    if (get_done(inst) !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout inst%0d a=%0d b=%0d: no done after %0d cycles", inst, a, b, lat);
    end
    n_vec++;
    if (lat != it.lat) begin
      n_fail++;
      $display("FAIL latency inst%0d a=%0d b=%0d: got %0d edges, want %0d", inst, a, b, lat, it.lat);
    end
    n_vec++;
    if (busyc != it.lat) begin
      n_fail++;
      $display("FAIL busy_cycles inst%0d a=%0d b=%0d: got %0d, want %0d", inst, a, b, busyc, it.lat);
    end
    n_vec++;
    if (get_prod(inst) !== it.prod || get_busy(inst) !== 1'b0) begin
      n_fail++;
      $display("FAIL product inst%0d a=%0d b=%0d: got %0d busy=%b, want %0d busy=0",
               inst, a, b, get_prod(inst), get_busy(inst), it.prod);
    end

    if (poke_done) set_in(inst, 1'b1, 16'd1, 16'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(inst, 1'b0, a, b);
    n_vec++;
    if (get_done(inst) !== 1'b0 || get_busy(inst) !== 1'b0 || get_prod(inst) !== it.prod) begin
      n_fail++;
      $display("FAIL after_done inst%0d: done=%b busy=%b prod=%0d, want 0/0/%0d",
               inst, get_done(inst), get_busy(inst), get_prod(inst), it.prod);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (get_prod(inst) !== it.prod || get_eqz(inst) !== 1'b1 || get_busy(inst) !== 1'b0) begin
      n_fail++;
      $display("FAIL hold inst%0d: prod=%0d eqz=%b busy=%b, want %0d/1/0",
               inst, get_prod(inst), get_eqz(inst), get_busy(inst), it.prod);
    end
  endtask

  task automatic test_basic;
    run_op(0, 16'd7, 16'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op(0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 25)), 1'b0, 1'b0);
  endtask

  task automatic test_zero_operands;
    run_op(0, 16'd1234, 16'd0, 1'b0, 1'b0);
    run_op(0, 16'd0, 16'd3, 1'b0, 1'b0);
  endtask

  task automatic test_max_width;
    run_op(1, 16'd15, 16'd15, 1'b0, 1'b0);
    run_op(1, 16'd9, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_swap;
    run_op(2, 16'd3, 16'd1000, 1'b1, 1'b1);
    run_op(2, 16'd1000, 16'd3, 1'b0, 1'b0);
    run_op(2, 16'd6, 16'd6, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op;
    int seen;
    @(negedge clk);
    set_in(0, 1'b1, 16'd9, 16'd9);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'd9, 16'd9);
    repeat (3) @(negedge clk);
    n_vec++;
    if (p0 !== 32'd27 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_partial: prod=%0d busy=%b, want 27/1", p0, busy0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (p0 !== 32'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || eqz0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: prod=%0d busy=%b done=%b eqz=%b, want 0/0/0/1", p0, busy0, done0, eqz0);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: %0d active cycles after reset, want 0", seen);
    end
    run_op(0, 16'd2, 16'd3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_operands();
    test_max_width();
    test_swap();
    test_reset_mid_op();
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
